// File: rtl/tff_ctr_pkg.sv
// tff_ctr_pkg: direction constants and the clamped modulo next-count function
package tff_ctr_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // 32-bit working width keeps the compares and the clamp free of overflow for any practical WIDTH
    function automatic logic [31:0] next_val(
        input logic [31:0] q,
        input logic        en,
        input logic        up,
        input logic        load,
        input logic [31:0] load_val,
        input logic [31:0] modulus
    );
        logic [31:0] last;
        last = modulus - 32'd1;
        if (load) return (load_val > last) ? last : load_val;
        if (!en) return q;
        if (up == DIR_UP) return (q == last) ? 32'd0 : q + 32'd1;
        return (q == 32'd0) ? last : q - 32'd1;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop, a D flop fed with t ^ q, async active-low reset
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    // flip on t, clear asynchronously on reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else q <= t ^ q;

endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: modulo-N up/down counter whose state lives only in toggle cells
module tff_updown_counter
    import tff_ctr_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_p
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] t;

    // the cells only see which bits differ between the current and next count
    always_comb begin
        nxt = WIDTH'(next_val(32'(q), en, up, load, 32'(load_val), 32'(MODULUS)));
        t   = q ^ nxt;
        tc  = en & ~load & ((up == DIR_UP) ? ({1'b0, q} == LAST) : (q == '0));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .t    (t[i]),
            .q    (q[i])
        );
    end

    // a wrap edge is any edge taken while tc is high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wrap_p <= 1'b0;
        else wrap_p <= tc;

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: directed vectors for MODULUS=10 plus hand sequences for MODULUS=16
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q10, q16;
    logic       tc10, tc16, wp10, wp16;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic       tc;
        logic [3:0] q;
        logic       wp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q10), .tc(tc10), .wrap_p(wp10)
    );

    tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q16), .tc(tc16), .wrap_p(wp16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input logic [3:0] v);
        load = l;
        en = e;
        up = u;
        load_val = v;
    endtask

    initial begin
        logic [3:0] tp, qp;
        vecs = '{
            '{1'b1, 1'b1, 1'b1, 4'd13, 1'b0, 4'd9, 1'b0},
            '{1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1},
            '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0},
            '{1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 4'd5, 1'b0},
            '{1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd6, 1'b0},
            '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd6, 1'b0},
            '{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0},
            '{1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0},
            '{1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1},
            '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 4'd9, 1'b0}
        };

        #12;
        chk("rst_q10", 32'(q10), 32'd0);
        chk("rst_q16", 32'(q16), 32'd0);
        chk("rst_wp10", 32'(wp10), 32'd0);
        chk("rst_wp16", 32'(wp16), 32'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
            #1;
            chk($sformatf("vec%0d_tc", i), 32'(tc10), 32'(vecs[i].tc));
            tick;
            chk($sformatf("vec%0d_q", i), 32'(q10), 32'(vecs[i].q));
            chk($sformatf("vec%0d_wrap", i), 32'(wp10), 32'(vecs[i].wp));
        end

        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        #1;
        rst_n = 1'b1;
        chk("seq_start_q", 32'(q16), 32'd0);
        for (int k = 0; k < 17; k++) begin
            #1;
            chk($sformatf("seq%0d_tc", k), 32'(tc16), 32'((k % 16) == 15));
            tp = u16.t;
            qp = q16;
            if (k == 7) chk("t_0111", 32'(tp), 32'hF);
            tick;
            chk($sformatf("seq%0d_q", k), 32'(q16), 32'((k + 1) % 16));
            chk($sformatf("seq%0d_wrap", k), 32'(wp16), 32'((k % 16) == 15));
            chk($sformatf("seq%0d_toggle", k), 32'(q16 ^ qp), 32'(tp));
        end

        drive(1'b1, 1'b0, 1'b1, 4'd7);
        tick;
        chk("hold_load", 32'(q16), 32'd7);
        drive(1'b0, 1'b0, 1'b1, 4'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d_t", k), 32'(u16.t), 32'd0);
            tick;
            chk($sformatf("hold%0d_q", k), 32'(q16), 32'd7);
            chk($sformatf("hold%0d_wrap", k), 32'(wp16), 32'd0);
        end

        drive(1'b1, 1'b0, 1'b1, 4'd12);
        tick;
        chk("arst_pre_q", 32'(q16), 32'd12);
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(q16), 32'd0);
        chk("arst_wrap", 32'(wp16), 32'd0);
        #2;
        rst_n = 1'b1;
        tick;
        chk("arst_first_q", 32'(q16), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: run did not finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
